// File: rtl/tankwar_pkg.sv
// Shared tank-war definitions: player encoding, default pool/cooldown sizes
// and the cooldown counter helper used by the bullet slot arbiter.
package tankwar_pkg;

    typedef enum logic {
        PLAYER1 = 1'b0,
        PLAYER2 = 1'b1
    } player_e;

    localparam int DEFAULT_MAX_BULLETS     = 8;
    localparam int DEFAULT_COOLDOWN_FRAMES = 8;
    localparam int DEFAULT_PER_PLAYER_MAX  = 4;

    // Cooldowns count frames up to 255.
    localparam int COOLDOWN_W = 8;

    // One frame of cooldown decay: count down on a tick, hold at zero.
    function automatic logic [COOLDOWN_W-1:0] cooldown_step(
        input logic [COOLDOWN_W-1:0] cd,
        input logic                  tick
    );
        if (tick && (cd != '0)) begin
            return cd - COOLDOWN_W'(1);
        end
        return cd;
    endfunction

endpackage

// File: rtl/bullet_slot_arbiter_free_slot_finder.sv
// Lowest-index free slot encoder over the occupancy bitmap. Purely
// combinational; free_idx is 0 when no slot is free (qualify with any_free).
module free_slot_finder
    import tankwar_pkg::*;
#(
    parameter int N     = DEFAULT_MAX_BULLETS,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     busy,
    output logic             any_free,
    output logic [IDX_W-1:0] free_idx
);

    // Scan from the top down so the last hit written is the lowest free index.
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                any_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/bullet_slot_arbiter.sv
// Bullet slot arbiter: owns the shared pool of bullet OAM slots, turns fire
// button edges into slot grants under a per-player live cap and a per-player
// frame cooldown, and takes slot releases from the collision logic.
//
// Optional build macro TANKWAR_BULLET_FLUSH_EN adds a 'flush' input that
// empties the pool (busy, owner, counts, pending) on round restart.
//
// Handshake: release_valid is a single-cycle strobe with no ready; the
// arbiter always accepts it, and a release naming an idle slot is dropped.
// grant_valid is likewise a one-cycle pulse with no back-pressure.
module bullet_slot_arbiter
    import tankwar_pkg::*;
#(
    parameter int MAX_BULLETS     = DEFAULT_MAX_BULLETS,
    parameter int PER_PLAYER_MAX  = DEFAULT_PER_PLAYER_MAX,
    parameter int COOLDOWN_FRAMES = DEFAULT_COOLDOWN_FRAMES,
    parameter int IDX_W           = $clog2(MAX_BULLETS)
) (
    input  logic                   clk,
    input  logic                   clrn,
    input  logic                   frame_tick,
    input  logic                   game_on,
    input  logic [1:0]             fire_req,
    input  logic                   release_valid,
    input  logic [IDX_W-1:0]       release_slot,
`ifdef TANKWAR_BULLET_FLUSH_EN
    input  logic                   flush,
`endif
    output logic                   grant_valid,
    output logic                   grant_player,
    output logic [IDX_W-1:0]       grant_slot,
    output logic [MAX_BULLETS-1:0] slot_busy,
    output logic [MAX_BULLETS-1:0] slot_owner,
    output logic [IDX_W:0]         live_count1,
    output logic [IDX_W:0]         live_count2
);

    localparam logic [IDX_W:0]          CAP     = (IDX_W + 1)'(PER_PLAYER_MAX);
    localparam logic [IDX_W:0]          CNT_ONE = (IDX_W + 1)'(1);
    localparam logic [COOLDOWN_W-1:0]   CD_LOAD = COOLDOWN_W'(COOLDOWN_FRAMES);

    // Registered state
    logic [1:0]             fire_q,    fire_d;
    logic [1:0]             pending_q, pending_d;
    logic [MAX_BULLETS-1:0] busy_q,    busy_d;
    logic [MAX_BULLETS-1:0] owner_q,   owner_d;
    logic [IDX_W:0]         cnt1_q,    cnt1_d;
    logic [IDX_W:0]         cnt2_q,    cnt2_d;
    logic [COOLDOWN_W-1:0]  cd1_q,     cd1_d;
    logic [COOLDOWN_W-1:0]  cd2_q,     cd2_d;
    logic                   rr_q,      rr_d;
    logic                   gv_q,      gv_d;
    logic                   gp_q,      gp_d;
    logic [IDX_W-1:0]       gs_q,      gs_d;

    // Combinational decision signals
    logic [1:0]       rise;
    logic [1:0]       cd_zero;
    logic [1:0]       eligible;
    logic             grant;
    logic             winner;
    logic             any_free;
    logic [IDX_W-1:0] free_idx;
    logic             rel_hit;
    logic             rel_owner;
    logic             flush_i;

`ifdef TANKWAR_BULLET_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    // Free slot search looks only at registered occupancy, so a slot freed
    // this cycle becomes grantable one cycle later.
    free_slot_finder #(
        .N     (MAX_BULLETS),
        .IDX_W (IDX_W)
    ) u_free_slot_finder (
        .busy     (busy_q),
        .any_free (any_free),
        .free_idx (free_idx)
    );

    // Edge detect, eligibility and round-robin arbitration between players.
    always_comb begin
        rise     = fire_req & ~fire_q;
        cd_zero  = {(cd2_q == '0), (cd1_q == '0)};
        eligible = 2'b00;
        grant    = 1'b0;
        winner   = PLAYER1;

        eligible[0] = game_on & pending_q[0] & cd_zero[0] & (cnt1_q < CAP) & any_free;
        eligible[1] = game_on & pending_q[1] & cd_zero[1] & (cnt2_q < CAP) & any_free;

        if (eligible == 2'b11) begin
            grant  = 1'b1;
            winner = rr_q;
        end else if (eligible[0]) begin
            grant  = 1'b1;
            winner = PLAYER1;
        end else if (eligible[1]) begin
            grant  = 1'b1;
            winner = PLAYER2;
        end

        // A round restart wins over any allocation in the same cycle.
        if (flush_i) begin
            grant = 1'b0;
        end
    end

    // Next-state for pool occupancy, counts, pending, cooldowns and grant.
    always_comb begin
        fire_d    = fire_req;
        busy_d    = busy_q;
        owner_d   = owner_q;
        cnt1_d    = cnt1_q;
        cnt2_d    = cnt2_q;
        pending_d = pending_q;
        rr_d      = rr_q;
        gv_d      = grant;
        gp_d      = gp_q;
        gs_d      = gs_q;
        rel_hit   = release_valid & busy_q[release_slot];
        rel_owner = owner_q[release_slot];

        // Release first, then allocation; they can never name the same slot
        // because the allocated slot is free and the released one is busy.
        if (rel_hit) begin
            busy_d[release_slot] = 1'b0;
        end
        if (grant) begin
            busy_d[free_idx]  = 1'b1;
            owner_d[free_idx] = winner;
            gp_d              = winner;
            gs_d              = free_idx;
            rr_d              = ~winner;
        end

        // Counts move by the net of grant and release; never below zero.
        if (grant && (winner == PLAYER1)) begin
            cnt1_d = cnt1_d + CNT_ONE;
        end
        if (grant && (winner == PLAYER2)) begin
            cnt2_d = cnt2_d + CNT_ONE;
        end
        if (rel_hit && (rel_owner == PLAYER1) && (cnt1_d != '0)) begin
            cnt1_d = cnt1_d - CNT_ONE;
        end
        if (rel_hit && (rel_owner == PLAYER2) && (cnt2_d != '0)) begin
            cnt2_d = cnt2_d - CNT_ONE;
        end

        // Pending gives a request at most one frame to find a slot. A fresh
        // edge accepted this cycle opens a new window even on a frame tick.
        if ((grant && (winner == PLAYER1)) || frame_tick || !game_on) begin
            pending_d[0] = 1'b0;
        end
        if ((grant && (winner == PLAYER2)) || frame_tick || !game_on) begin
            pending_d[1] = 1'b0;
        end
        if (rise[0] && cd_zero[0] && game_on) begin
            pending_d[0] = 1'b1;
        end
        if (rise[1] && cd_zero[1] && game_on) begin
            pending_d[1] = 1'b1;
        end

        // A grant reloads the winner's cooldown; otherwise it decays per frame.
        cd1_d = (grant && (winner == PLAYER1)) ? CD_LOAD : cooldown_step(cd1_q, frame_tick);
        cd2_d = (grant && (winner == PLAYER2)) ? CD_LOAD : cooldown_step(cd2_q, frame_tick);

        if (flush_i) begin
            busy_d    = '0;
            owner_d   = '0;
            cnt1_d    = '0;
            cnt2_d    = '0;
            pending_d = '0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            fire_q    <= '0;
            pending_q <= '0;
            busy_q    <= '0;
            owner_q   <= '0;
            cnt1_q    <= '0;
            cnt2_q    <= '0;
            cd1_q     <= '0;
            cd2_q     <= '0;
            rr_q      <= PLAYER1;
            gv_q      <= 1'b0;
            gp_q      <= 1'b0;
            gs_q      <= '0;
        end else begin
            fire_q    <= fire_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
            owner_q   <= owner_d;
            cnt1_q    <= cnt1_d;
            cnt2_q    <= cnt2_d;
            cd1_q     <= cd1_d;
            cd2_q     <= cd2_d;
            rr_q      <= rr_d;
            gv_q      <= gv_d;
            gp_q      <= gp_d;
            gs_q      <= gs_d;
        end
    end

    assign grant_valid  = gv_q;
    assign grant_player = gp_q;
    assign grant_slot   = gs_q;
    assign slot_busy    = busy_q;
    assign slot_owner   = owner_q;
    assign live_count1  = cnt1_q;
    assign live_count2  = cnt2_q;

endmodule

// File: tb/tb_bullet_slot_arbiter.sv
// Self-checking bench for bullet_slot_arbiter (default parameters: 8 slots,
// 4 per player, 8-frame cooldown). Directed table and sequences plus a
// randomized run against a slot-ownership reference model.
module tb_bullet_slot_arbiter;
    import tankwar_pkg::*;

    localparam int MAXB = 8;
    localparam int PPM  = 4;
    localparam int CDF  = 8;
    localparam int IW   = 3;

    // ---------------- clock / reset / DUT ----------------
    logic            clk = 1'b0;
    logic            clrn;
    logic            frame_tick;
    logic            game_on;
    logic [1:0]      fire_req;
    logic            release_valid;
    logic [IW-1:0]   release_slot;
    logic            flush_v = 1'b0;
    logic            grant_valid;
    logic            grant_player;
    logic [IW-1:0]   grant_slot;
    logic [MAXB-1:0] slot_busy;
    logic [MAXB-1:0] slot_owner;
    logic [IW:0]     live_count1;
    logic [IW:0]     live_count2;

    always #5 clk = ~clk;

    bullet_slot_arbiter dut (
        .clk           (clk),
        .clrn          (clrn),
        .frame_tick    (frame_tick),
        .game_on       (game_on),
        .fire_req      (fire_req),
        .release_valid (release_valid),
        .release_slot  (release_slot),
`ifdef TANKWAR_BULLET_FLUSH_EN
        .flush         (flush_v),
`endif
        .grant_valid   (grant_valid),
        .grant_player  (grant_player),
        .grant_slot    (grant_slot),
        .slot_busy     (slot_busy),
        .slot_owner    (slot_owner),
        .live_count1   (live_count1),
        .live_count2   (live_count2)
    );

    int total = 0;
    int bad   = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Pool as an array of owners (-1 = free); counts derived by counting.
    int          m_own[MAXB];
    bit          m_pend[2];
    int          m_cd[2];
    bit [1:0]    m_fire_prev;
    bit          m_rr;
    bit          m_gv;
    logic [IW:0] exp_q[$];

    function automatic int m_count(input int p);
        int c = 0;
        for (int i = 0; i < MAXB; i++) if (m_own[i] == p) c++;
        return c;
    endfunction

    function automatic logic [MAXB-1:0] m_busy();
        logic [MAXB-1:0] b = '0;
        for (int i = 0; i < MAXB; i++) b[i] = (m_own[i] >= 0);
        return b;
    endfunction

    function automatic logic [MAXB-1:0] m_owner();
        logic [MAXB-1:0] b = '0;
        for (int i = 0; i < MAXB; i++) b[i] = (m_own[i] == 1);
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < MAXB; i++) m_own[i] = -1;
        m_pend[0] = 0; m_pend[1] = 0;
        m_cd[0] = 0; m_cd[1] = 0;
        m_fire_prev = 2'b00;
        m_rr = 0;
        m_gv = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic [1:0] fire, input logic ft, input logic gon,
                              input logic rv, input logic [IW-1:0] rs, input logic fl);
        bit elig[2];
        int first_free = -1;
        bit gp = 0;
        for (int i = MAXB - 1; i >= 0; i--) if (m_own[i] < 0) first_free = i;
        for (int p = 0; p < 2; p++)
            elig[p] = gon && m_pend[p] && (m_cd[p] == 0) && (m_count(p) < PPM) && (first_free >= 0);
        m_gv = (elig[0] || elig[1]) && !fl;
        if (elig[0] && elig[1]) gp = m_rr;
        else gp = elig[1];
        for (int p = 0; p < 2; p++) begin
            if (fl) m_pend[p] = 0;
            else if (fire[p] && !m_fire_prev[p] && (m_cd[p] == 0) && gon) m_pend[p] = 1;
            else if ((m_gv && gp == p) || ft || !gon) m_pend[p] = 0;
        end
        m_fire_prev = fire;
        if (rv && m_own[rs] >= 0) m_own[rs] = -1;
        if (fl) for (int i = 0; i < MAXB; i++) m_own[i] = -1;
        if (m_gv) begin
            m_own[first_free] = gp;
            m_rr = !gp;
            exp_q.push_back({gp, IW'(first_free)});
        end
        for (int p = 0; p < 2; p++) begin
            if (m_gv && gp == p) m_cd[p] = CDF;
            else if (ft && m_cd[p] > 0) m_cd[p]--;
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check_all();
        logic [IW:0] e;
        bit have = 0;
        check("grant_valid", grant_valid, m_gv);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            have = 1;
        end
        if (grant_valid === 1'b1) begin
            if (!have) begin
                total++; bad++;
                $display("FAIL grant_unexpected: got slot %0d expected no grant", grant_slot);
            end else begin
                check("grant_player", grant_player, e[IW]);
                check("grant_slot", grant_slot, e[IW-1:0]);
            end
        end
        check("slot_busy", slot_busy, m_busy());
        check("slot_owner", slot_owner & m_busy(), m_owner());
        check("live_count1", live_count1, m_count(0));
        check("live_count2", live_count2, m_count(1));
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge: apply inputs, let one edge pass, compare at negedge.
    task automatic step(input logic [1:0] f, input logic ft, input logic rv, input logic [IW-1:0] rs);
        fire_req = f; frame_tick = ft; release_valid = rv; release_slot = rs;
        @(posedge clk);
        model_step(f, ft, game_on, rv, rs, flush_v);
        @(negedge clk);
        check_all();
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) begin
            step(2'b00, 1'b1, 1'b0, '0);
            step(2'b00, 1'b0, 1'b0, '0);
        end
    endtask

    task automatic do_reset();
        clrn = 1'b0; fire_req = 2'b00; frame_tick = 1'b0; release_valid = 1'b0;
        release_slot = '0; flush_v = 1'b0; game_on = 1'b1;
        @(posedge clk); @(posedge clk); @(negedge clk);
        clrn = 1'b1;
        model_reset();
        check("rst_grant_valid", grant_valid, 0);
        check("rst_busy", slot_busy, 0);
        check("rst_owner", slot_owner, 0);
        check("rst_count1", live_count1, 0);
        check("rst_count2", live_count2, 0);
    endtask

    // Both players fire together, each gets a slot, then cooldown expires.
    task automatic both_round();
        step(2'b11, 1'b0, 1'b0, '0);
        step(2'b11, 1'b0, 1'b0, '0);
        step(2'b11, 1'b0, 1'b0, '0);
        step(2'b00, 1'b0, 1'b0, '0);
        frames(CDF);
    endtask

    typedef struct {
        logic [1:0]      fire;
        logic            ft;
        logic            exp_gv;
        logic            exp_gp;
        logic [IW-1:0]   exp_gs;
        logic [MAXB-1:0] exp_busy;
        logic [IW:0]     exp_c1;
    } vec_t;

    vec_t vt[13];

    initial begin
        // ---- table: single uncontended grant, latency 2 ----
        for (int i = 0; i < 10; i++) vt[i] = '{2'b00, (i == 5), 1'b0, 1'b0, '0, '0, '0};
        vt[10] = '{2'b01, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 4'd0};
        vt[11] = '{2'b01, 1'b0, 1'b1, 1'b0, 3'd0, 8'h01, 4'd1};
        vt[12] = '{2'b01, 1'b0, 1'b0, 1'b0, 3'd0, 8'h01, 4'd1};

        do_reset();
        for (int i = 0; i < 13; i++) begin
            step(vt[i].fire, vt[i].ft, 1'b0, '0);
            check("tbl_gv", grant_valid, vt[i].exp_gv);
            if (vt[i].exp_gv) begin
                check("tbl_gp", grant_player, vt[i].exp_gp);
                check("tbl_gs", grant_slot, vt[i].exp_gs);
            end
            check("tbl_busy", slot_busy, vt[i].exp_busy);
            check("tbl_c1", live_count1, vt[i].exp_c1);
        end
        for (int i = 0; i < 50; i++) begin
            step(2'b01, 1'b0, 1'b0, '0);
            check("hold_no_regrant", grant_valid, 0);
        end

        // ---- reset in the arbitration cycle discards the grant ----
        do_reset();
        step(2'b01, 1'b0, 1'b0, '0);
        clrn = 1'b0;
        @(posedge clk); @(negedge clk);
        clrn = 1'b1;
        model_reset();
        check("rst_mid_gv", grant_valid, 0);
        check("rst_mid_busy", slot_busy, 0);
        step(2'b00, 1'b0, 1'b0, '0);
        check("rst_mid_after_gv", grant_valid, 0);

        // ---- simultaneous fire: p1 first, p2 next cycle ----
        do_reset();
        step(2'b11, 1'b0, 1'b0, '0);
        step(2'b11, 1'b0, 1'b0, '0);
        check("both_first_gv", grant_valid, 1);
        check("both_first_gp", grant_player, 0);
        check("both_first_gs", grant_slot, 0);
        step(2'b11, 1'b0, 1'b0, '0);
        check("both_second_gv", grant_valid, 1);
        check("both_second_gp", grant_player, 1);
        check("both_second_gs", grant_slot, 1);
        step(2'b00, 1'b0, 1'b0, '0);
        frames(CDF);
        step(2'b11, 1'b0, 1'b0, '0);
        step(2'b11, 1'b0, 1'b0, '0);
        step(2'b11, 1'b0, 1'b0, '0);
        step(2'b00, 1'b0, 1'b0, '0);

        // ---- cooldown blocks a re-fire until the 8th frame ----
        do_reset();
        step(2'b01, 1'b0, 1'b0, '0);
        step(2'b01, 1'b0, 1'b0, '0);
        step(2'b00, 1'b0, 1'b0, '0);
        frames(3);
        step(2'b01, 1'b0, 1'b0, '0);
        step(2'b01, 1'b0, 1'b0, '0);
        check("cd_block_gv1", grant_valid, 0);
        step(2'b01, 1'b0, 1'b0, '0);
        check("cd_block_gv2", grant_valid, 0);
        step(2'b00, 1'b0, 1'b0, '0);
        frames(5);
        step(2'b01, 1'b0, 1'b0, '0);
        step(2'b01, 1'b0, 1'b0, '0);
        check("cd_done_gv", grant_valid, 1);
        check("cd_done_gs", grant_slot, 1);
        step(2'b00, 1'b0, 1'b0, '0);

        // ---- per-player cap, pending drop on frame tick, reuse slot 2 ----
        do_reset();
        for (int r = 0; r < PPM; r++) begin
            step(2'b01, 1'b0, 1'b0, '0);
            step(2'b01, 1'b0, 1'b0, '0);
            step(2'b00, 1'b0, 1'b0, '0);
            frames(CDF);
        end
        check("cap_busy", slot_busy, 8'h0F);
        check("cap_c1", live_count1, 4);
        step(2'b01, 1'b0, 1'b0, '0);
        step(2'b01, 1'b0, 1'b0, '0);
        check("cap_no_gv", grant_valid, 0);
        step(2'b00, 1'b1, 1'b0, '0);
        step(2'b00, 1'b0, 1'b1, 3'd2);
        check("cap_rel_busy", slot_busy, 8'h0B);
        check("cap_rel_c1", live_count1, 3);
        step(2'b00, 1'b0, 1'b0, '0);
        step(2'b00, 1'b0, 1'b0, '0);
        check("cap_dropped_gv", grant_valid, 0);
        step(2'b01, 1'b0, 1'b0, '0);
        step(2'b01, 1'b0, 1'b0, '0);
        check("cap_reuse_gv", grant_valid, 1);
        check("cap_reuse_gs", grant_slot, 2);
        check("cap_reuse_c1", live_count1, 4);
        step(2'b00, 1'b0, 1'b0, '0);

        // ---- full pool, release coinciding with pending p2 ----
        do_reset();
        for (int r = 0; r < 4; r++) both_round();
        check("full_busy", slot_busy, 8'hFF);
        check("full_c2", live_count2, 4);
        step(2'b10, 1'b0, 1'b0, '0);
        step(2'b00, 1'b0, 1'b1, 3'd5);
        check("full_rel_gv", grant_valid, 0);
        check("full_rel_busy", slot_busy, 8'hDF);
        check("full_rel_c2", live_count2, 3);
        step(2'b00, 1'b0, 1'b0, '0);
        check("full_next_gv", grant_valid, 1);
        check("full_next_gp", grant_player, 1);
        check("full_next_gs", grant_slot, 5);
        step(2'b00, 1'b0, 1'b1, 3'd5);
        step(2'b00, 1'b0, 1'b1, 3'd5);
        check("idle_rel_busy", slot_busy, 8'hDF);
        check("idle_rel_c1", live_count1, 4);
        check("idle_rel_c2", live_count2, 3);

`ifdef TANKWAR_BULLET_FLUSH_EN
        // ---- flush empties the pool and suppresses a concurrent grant ----
        do_reset();
        for (int r = 0; r < 3; r++) both_round();
        check("flush_pre_busy", slot_busy, 8'h3F);
        step(2'b01, 1'b0, 1'b0, '0);
        flush_v = 1'b1;
        step(2'b00, 1'b0, 1'b0, '0);
        flush_v = 1'b0;
        check("flush_gv", grant_valid, 0);
        check("flush_busy", slot_busy, 0);
        check("flush_c1", live_count1, 0);
        check("flush_c2", live_count2, 0);
        step(2'b00, 1'b0, 1'b0, '0);
        check("flush_after_gv", grant_valid, 0);
`endif

        // ---- randomized run against the model ----
        do_reset();
        begin
            logic [1:0] f = 2'b00;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(0, 3) == 0) f[0] = ~f[0];
                if ($urandom_range(0, 3) == 0) f[1] = ~f[1];
                if ($urandom_range(0, 199) == 0) game_on = ~game_on;
                if (!game_on && $urandom_range(0, 19) == 0) game_on = 1'b1;
`ifdef TANKWAR_BULLET_FLUSH_EN
                flush_v = ($urandom_range(0, 199) == 0);
`endif
                step(f, ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
                     IW'($urandom_range(0, MAXB - 1)));
            end
            flush_v = 1'b0;
        end
        check("exp_q_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
